// File: rtl/ex_multiplier.sv
// ex_multiplier
//   Multi-cycle 32x32 integer multiplier for the EX stage. It implements
//   MUL, MULH, MULHSU and MULHU. Each request takes exactly five busy
//   cycles before the single-cycle done pulse:
//     - four CALC cycles, each accumulating |a| x one byte of |b|
//     - one FIX cycle that applies the sign and selects the result half
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a multiply (sampled on the rising edge)
//   alu_op     operation code; only the four MUL codes are accepted
//   op_a       rs1 operand
//   op_b       rs2 operand
//   flush      abort any operation in flight
//   busy       high in CALC and FIX; stalls the EX stage
//   done       one-cycle pulse while mul_result holds a fresh result
//   mul_result registered result; held until the next FIX load
module ex_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  alu_op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] mul_result
);

   localparam int unsigned DATA_W = 32;

   localparam logic [3:0] ALU_MUL    = 4'hA;
   localparam logic [3:0] ALU_MULH   = 4'hB;
   localparam logic [3:0] ALU_MULHSU = 4'hC;
   localparam logic [3:0] ALU_MULHU  = 4'hD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_next;

   logic [DATA_W-1:0]       a_mag;
   logic [DATA_W-1:0]       b_mag;
   logic                    negate;
   logic                    sel_hi;
   logic [1:0]              cnt;
   logic [2*DATA_W-1:0]     acc;

   logic                    is_mul;
   logic                    accept;
   logic                    sign_a;
   logic                    sign_b;
   logic [2*DATA_W-1:0]     fixed;

   // Magnitude of a possibly signed operand. 0x80000000 maps to 2^31,
   // which still fits in 32 unsigned bits, so no overflow special case.
   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                   input logic use_sign);
      logic signed [DATA_W-1:0] n;
      n = -v;
      if (use_sign && v[DATA_W-1])
         return $unsigned(n);
      else
         return $unsigned(v);
   endfunction

   function automatic logic [2*DATA_W-1:0] negate64(input logic [2*DATA_W-1:0] v);
      return ~v + {{(2*DATA_W-1){1'b0}}, 1'b1};
   endfunction

   // One radix-256 partial product: |a| x byte[k] of |b|, weighted by 2^(8k).
   function automatic logic [2*DATA_W-1:0] partial(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [1:0]        k);
      logic [7:0]          b_byte;
      logic [2*DATA_W-1:0] pp;
      b_byte = b[{k, 3'b000} +: 8];
      pp     = {{DATA_W{1'b0}}, a} * {{(2*DATA_W-8){1'b0}}, b_byte};
      return pp << {k, 3'b000};
   endfunction

   always_comb begin
      is_mul = (alu_op == ALU_MUL)    || (alu_op == ALU_MULH) ||
               (alu_op == ALU_MULHSU) || (alu_op == ALU_MULHU);
      accept = start && !flush && is_mul && ((state == IDLE) || (state == DONE));
      // op_a is unsigned only for MULHU; op_b is signed only for MUL/MULH.
      sign_a = op_a[DATA_W-1] && (alu_op != ALU_MULHU);
      sign_b = op_b[DATA_W-1] && ((alu_op == ALU_MUL) || (alu_op == ALU_MULH));
      fixed  = negate ? negate64(acc) : acc;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = CALC;
         CALC:    if (cnt == 2'd3) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = accept ? CALC : IDLE;
         default: state_next = IDLE;
      endcase
      if (flush)
         state_next = IDLE;
   end

   always_comb begin
      busy = (state == CALC) || (state == FIX);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mul_result <= '0;
         cnt        <= '0;
         acc        <= '0;
         a_mag      <= '0;
         b_mag      <= '0;
         negate     <= 1'b0;
         sel_hi     <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            a_mag  <= magnitude($signed(op_a), sign_a);
            b_mag  <= magnitude($signed(op_b), sign_b);
            negate <= sign_a ^ sign_b;
            sel_hi <= (alu_op != ALU_MUL);
            cnt    <= '0;
            acc    <= '0;
         end else if ((state == CALC) && !flush) begin
            acc <= acc + partial(a_mag, b_mag, cnt);
            cnt <= cnt + 2'd1;
         end else if ((state == FIX) && !flush) begin
            mul_result <= sel_hi ? fixed[2*DATA_W-1:DATA_W] : fixed[DATA_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_ex_multiplier.sv
module tb_ex_multiplier;

   localparam logic [3:0] ALU_ADD    = 4'h0;
   localparam logic [3:0] ALU_MUL    = 4'hA;
   localparam logic [3:0] ALU_MULH   = 4'hB;
   localparam logic [3:0] ALU_MULHSU = 4'hC;
   localparam logic [3:0] ALU_MULHU  = 4'hD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  alu_op = 4'h0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] mul_result;

   ex_multiplier dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .alu_op     (alu_op),
      .op_a       (op_a),
      .op_b       (op_b),
      .flush      (flush),
      .busy       (busy),
      .done       (done),
      .mul_result (mul_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t        q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [31:0] last_res  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: extend each operand to 64 bits per its signedness and take the
   // full product modulo 2^64; MUL returns the low word, the rest the high word.
   function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == ALU_MULHU) ? {32'd0, a} : {{32{a[31]}}, a};
      eb = ((op == ALU_MUL) || (op == ALU_MULH)) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (op == ALU_MUL) ? p[31:0] : p[63:32];
   endfunction

   // Drive one request; call away from the rising edge. Returns 1 unit after
   // the sampling edge with start/flush released.
   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl);
      start  = 1'b1;
      alu_op = op;
      op_a   = a;
      op_b   = b;
      flush  = fl;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      exp_t e;
      drive(op, a, b, 1'b0);
      e.res = exp;
      e.due = cyc + 5;
      q.push_back(e);
      last_res = exp;
   endtask

   task automatic wait_done(output int nbusy);
      bit seen;
      nbusy = 0;
      seen  = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) nbusy++;
      end
      if (!seen) check("wait_done_timeout", done, 1);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents done.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (q.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            e = q.pop_front();
            check("result", mul_result, e.res);
            check("latency", cyc, e.due);
         end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
         check("done_at_due", done, 1);
         void'(q.pop_front());
      end
   end

   logic [31:0] corners [8] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h0000_00FF, 32'hFF00_0000, 32'h8000_0001};
   logic [3:0]  mul_ops [4] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};

   function automatic logic [31:0] pick_operand();
      if ($urandom_range(0, 3) == 0)
         return corners[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   initial begin
      int          nb;
      logic [31:0] held;
      bit          chain;
      logic [3:0]  op;
      logic [31:0] a, b;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", mul_result, 32'h0);

      // Basic MUL with busy-length measurement.
      @(negedge clk);
      issue(ALU_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      wait_done(nb);
      check("mul_busy_cycles", nb, 5);

      // MULH corner; a start during CALC must be ignored.
      @(negedge clk);
      issue(ALU_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      @(negedge clk);
      drive(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      wait_done(nb);

      @(negedge clk);
      issue(ALU_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
      wait_done(nb);

      @(negedge clk);
      issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(nb);

      // Back-to-back: second start during DONE, first result held until FIX.
      @(negedge clk);
      issue(ALU_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
      wait_done(nb);
      held = 32'h0005_000F;
      issue(ALU_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("b2b_held_result", mul_result, held);
         check("b2b_busy", busy, 1);
      end
      wait_done(nb);

      // Flush in CALC cycle 2.
      @(negedge clk);
      drive(ALU_MUL, 32'h0000_1111, 32'h0000_2222, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_done", done, 0);
      check("flush_result_held", mul_result, last_res);
      @(negedge clk);
      drive(ALU_ADD, 32'h0000_0003, 32'h0000_0004, 1'b0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("add_ignored_busy", busy, 0);
      end
      check("add_ignored_result", mul_result, last_res);

      // Flush wins over a same-cycle start.
      @(negedge clk);
      drive(ALU_MUL, 32'h0000_0009, 32'h0000_0009, 1'b1);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("flush_start_busy", busy, 0);
      end
      check("flush_start_result", mul_result, last_res);

      // Reset during FIX.
      @(negedge clk);
      drive(ALU_MUL, 32'h0000_0010, 32'h0000_0010, 1'b0);
      repeat (5) @(negedge clk);
      check("fix_busy_before_rst", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      last_res = '0;
      check("rst_fix_result", mul_result, 32'h0);
      check("rst_fix_busy", busy, 0);
      check("rst_fix_done", done, 0);
      repeat (8) @(negedge clk);
      issue(ALU_MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF);
      wait_done(nb);

      // Randomized traffic, sometimes back-to-back.
      chain = 0;
      for (int i = 0; i < 60; i++) begin
         if (!chain) @(negedge clk);
         a = pick_operand();
         b = pick_operand();
         if ($urandom_range(0, 9) == 9) begin
            drive(ALU_ADD, a, b, 1'b0);
            @(negedge clk);
            check("rand_ignored_busy", busy, 0);
            chain = 0;
         end else begin
            op = mul_ops[$urandom_range(0, 3)];
            issue(op, a, b, ref_mul(op, a, b));
            wait_done(nb);
            chain = $urandom_range(0, 1) == 1;
         end
      end

      repeat (10) @(negedge clk);
      check("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
